// File: rtl/prach_pkg.sv
// rtl/prach_pkg.sv - shared defaults and read-FSM state type for the PRACH un-reshaper
package prach_pkg;

  localparam int SIZE_DEF = 64;
  localparam int NCH_DEF  = 4;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Index width that stays at least one bit for degenerate sizes of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prach_unreshape_ch_if.sv
// rtl/prach_unreshape_ch_if.sv - input/output beat signals of the PRACH un-reshaper
interface prach_unreshape_ch_if;

  logic [15:0] din_dp1;
  logic [15:0] din_dp2;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [15:0] dout_dq1;
  logic [15:0] dout_dq2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err;

  modport master (
    output din_dp1, din_dp2, din_dv, din_chn, sync_in,
    input  dout_dq1, dout_dq2, dout_dv, dout_chn, sync_out, err
  );

  modport slave (
    input  din_dp1, din_dp2, din_dv, din_chn, sync_in,
    output dout_dq1, dout_dq2, dout_dv, dout_chn, sync_out, err
  );

endinterface

// File: rtl/prach_dpram.sv
// rtl/prach_dpram.sv - simple dual-port RAM, one write port, registered read port
module prach_dpram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/prach_unreshape_ch.sv
// rtl/prach_unreshape_ch.sv - channel-major to sample-major reorder through a ping-pong buffer
module prach_unreshape_ch
  import prach_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int NCH  = NCH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prach_unreshape_ch_if.slave  bus
);

  localparam int KW = idx_w(SIZE);
  localparam int CW = idx_w(NCH);
  localparam int BW = idx_w(NCH * SIZE);
  localparam int AW = BW + 1;

  logic [KW-1:0] wr_k, rd_k, beat_k;
  logic [CW-1:0] wr_ch, rd_ch, beat_ch;
  logic          wr_bank, rd_bank;
  rd_state_e     state;

  logic          beat_last, bank_full, rd_active, rd_last, overflow, ch_mismatch;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   ram_q;

  logic          s1_vld, s1_sync;
  logic [CW-1:0] s1_ch;

  // A sync beat is placed at index 0 regardless of where the counters were.
  always_comb begin
    beat_ch     = bus.sync_in ? '0 : wr_ch;
    beat_k      = bus.sync_in ? '0 : wr_k;
    beat_last   = (beat_ch == CW'(NCH - 1)) && (beat_k == KW'(SIZE - 1));
    bank_full   = bus.din_dv && beat_last;
    rd_active   = (state == RD_READ);
    rd_last     = rd_active && (rd_ch == CW'(NCH - 1)) && (rd_k == KW'(SIZE - 1));
    overflow    = bank_full && rd_active && !rd_last;
    ch_mismatch = bus.din_dv && (bus.din_chn != 8'(beat_ch));
    wr_addr     = {wr_bank, BW'(beat_ch) * BW'(SIZE) + BW'(beat_k)};
    rd_addr     = {rd_bank, BW'(rd_ch) * BW'(SIZE) + BW'(rd_k)};
  end

  // On overflow the write bank is not toggled, so the bank under read is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_ch   <= '0;
      wr_k    <= '0;
    end else if (bus.din_dv) begin
      if (beat_last) begin
        wr_ch <= '0;
        wr_k  <= '0;
        if (!overflow) wr_bank <= ~wr_bank;
      end else if (beat_k == KW'(SIZE - 1)) begin
        wr_ch <= beat_ch + CW'(1);
        wr_k  <= '0;
      end else begin
        wr_ch <= beat_ch;
        wr_k  <= beat_k + KW'(1);
      end
    end else if (bus.sync_in) begin
      wr_ch <= '0;
      wr_k  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_ch   <= '0;
      rd_k    <= '0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (bank_full) begin
            state   <= RD_READ;
            rd_bank <= wr_bank;
            rd_ch   <= '0;
            rd_k    <= '0;
          end
        end
        RD_READ: begin
          if (rd_last) begin
            rd_ch <= '0;
            rd_k  <= '0;
            if (bank_full) rd_bank <= wr_bank;
            else           state   <= RD_IDLE;
          end else if (rd_ch == CW'(NCH - 1)) begin
            rd_ch <= '0;
            rd_k  <= rd_k + KW'(1);
          end else begin
            rd_ch <= rd_ch + CW'(1);
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  prach_dpram #(.DW(32), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (bus.din_dv),
    .waddr (wr_addr),
    .wdata ({bus.din_dp1, bus.din_dp2}),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Stage 1 tracks the RAM read latency; stage 2 is the zero-when-idle output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld       <= 1'b0;
      s1_sync      <= 1'b0;
      s1_ch        <= '0;
      bus.dout_dv  <= 1'b0;
      bus.dout_dq1 <= '0;
      bus.dout_dq2 <= '0;
      bus.dout_chn <= '0;
      bus.sync_out <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      s1_vld       <= rd_active;
      s1_sync      <= rd_active && (rd_ch == '0) && (rd_k == '0);
      s1_ch        <= rd_ch;
      bus.dout_dv  <= s1_vld;
      bus.dout_dq1 <= s1_vld ? ram_q[31:16] : '0;
      bus.dout_dq2 <= s1_vld ? ram_q[15:0] : '0;
      bus.dout_chn <= s1_vld ? 8'(s1_ch) : '0;
      bus.sync_out <= s1_vld && s1_sync;
      bus.err      <= ch_mismatch || overflow;
    end
  end

endmodule

// File: tb/tb_prach_unreshape_ch.sv
// tb/tb_prach_unreshape_ch.sv - directed self-checking bench for prach_unreshape_ch
module tb_prach_unreshape_ch;

  localparam int NCH  = 4;
  localparam int SIZE = 64;
  localparam int NB   = NCH * SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  prach_unreshape_ch_if bus();

  prach_unreshape_ch #(.SIZE(SIZE), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int err_cnt = 0;
  int idle_bad = 0;
  int last_cyc = 0;

  typedef struct {
    logic [15:0] dq1;
    logic [15:0] dq2;
    logic [7:0]  chn;
    logic        sync;
    int          cyc;
  } beat_t;

  beat_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dout_dv === 1'b1)
      q.push_back('{bus.dout_dq1, bus.dout_dq2, bus.dout_chn, bus.sync_out, cyc});
    else if (bus.dout_dq1 !== 16'h0 || bus.dout_dq2 !== 16'h0 || bus.dout_chn !== 8'h0 || bus.sync_out !== 1'b0)
      idle_bad++;
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int n, input logic sync, input logic [7:0] tag, input int salt);
    logic [15:0] d;
    d = {8'(n / SIZE), 8'(n % SIZE)};
    @(negedge clk);
    bus.din_dv  = 1'b1;
    bus.sync_in = sync;
    bus.din_chn = tag;
    bus.din_dp1 = d;
    bus.din_dp2 = ~d ^ (16'(salt) << 12);
    last_cyc    = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.din_dv  = 1'b0;
    bus.sync_in = 1'b0;
    bus.din_chn = 8'h0;
    bus.din_dp1 = 16'h0;
    bus.din_dp2 = 16'h0;
  endtask

  task automatic send_block(input int salt, input int bad, input bit duty);
    logic [7:0] tag;
    for (int n = 0; n < NB; n++) begin
      if (duty && ($urandom_range(0, 1) == 1)) idle();
      tag = (n == bad) ? 8'd3 : 8'(n / SIZE);
      beat(n, n == 0, tag, salt);
    end
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (q.size() >= n) break;
      @(negedge clk);
      #1;
    end
    repeat (8) @(negedge clk);
    #1;
  endtask

  task automatic check_block(input int base, input int salt, input string tag);
    int bad;
    logic [15:0] e1;
    beat_t b;
    bad = 0;
    if (q.size() < base + NB) begin
      check({tag, " beats present"}, q.size(), base + NB);
    end else begin
      for (int n = 0; n < NB; n++) begin
        b  = q[base + n];
        e1 = {8'(n % NCH), 8'(n / NCH)};
        if (b.dq1 !== e1 || b.dq2 !== (~e1 ^ (16'(salt) << 12)) || b.chn !== 8'(n % NCH) ||
            b.sync !== (n == 0) || b.cyc != q[base].cyc + n)
          bad++;
      end
      check({tag, " bad beats"}, bad, 0);
    end
  endtask

  initial begin
    int s_last;
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.din_chn = 8'h0;
    bus.din_dp1 = 16'h0; bus.din_dp2 = 16'h0;
    repeat (3) @(negedge clk);
    check("reset dout_dv", bus.dout_dv, 1'b0);
    check("reset dout_dq1", bus.dout_dq1, 16'h0);
    check("reset dout_dq2", bus.dout_dq2, 16'h0);
    check("reset dout_chn", bus.dout_chn, 8'h0);
    check("reset sync_out", bus.sync_out, 1'b0);
    check("reset err", bus.err, 1'b0);
    rst_n = 1'b1;

    // one block, full rate
    send_block(0, -1, 1'b0);
    s_last = last_cyc;
    idle();
    wait_q(NB);
    check("s1 count", q.size(), NB);
    check("s1 latency", q[0].cyc, s_last + 3);
    check_block(0, 0, "s1");
    check("s1 err", err_cnt, 0);

    // three back-to-back blocks; second and third fill exactly as a read finishes
    q.delete(); err_cnt = 0;
    send_block(1, -1, 1'b0);
    send_block(2, -1, 1'b0);
    send_block(3, -1, 1'b0);
    idle();
    wait_q(3 * NB);
    check("s2 count", q.size(), 3 * NB);
    check_block(0, 1, "s2 blk0");
    check_block(NB, 2, "s2 blk1");
    check_block(2 * NB, 3, "s2 blk2");
    check("s2 contiguous", q[3 * NB - 1].cyc - q[0].cyc, 3 * NB - 1);
    check("s2 err", err_cnt, 0);

    // half duty input
    q.delete(); err_cnt = 0;
    send_block(0, -1, 1'b1);
    idle();
    wait_q(NB);
    check("s3 count", q.size(), NB);
    check_block(0, 0, "s3");
    check("s3 err", err_cnt, 0);

    // re-sync after 100 beats discards the partial block
    q.delete(); err_cnt = 0;
    for (int n = 0; n < 100; n++) beat(n, n == 0, 8'(n / SIZE), 5);
    send_block(0, -1, 1'b0);
    idle();
    wait_q(NB);
    check("s4 count", q.size(), NB);
    check_block(0, 0, "s4");
    check("s4 err", err_cnt, 0);

    // wrong channel tag on beat 5
    q.delete(); err_cnt = 0;
    send_block(0, 5, 1'b0);
    idle();
    wait_q(NB);
    check("s5 count", q.size(), NB);
    check_block(0, 0, "s5");
    check("s5 err pulses", err_cnt, 1);

    // reset during the 10th output beat
    q.delete(); err_cnt = 0;
    send_block(0, -1, 1'b0);
    idle();
    for (int i = 0; i < 600 && q.size() < 10; i++) begin
      @(negedge clk);
      #1;
    end
    check("s6 reached beat 10", q.size(), 10);
    rst_n = 1'b0;
    #1;
    check("s6 rst dout_dv", bus.dout_dv, 1'b0);
    check("s6 rst dout_dq1", bus.dout_dq1, 16'h0);
    check("s6 rst dout_chn", bus.dout_chn, 8'h0);
    repeat (3) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("s6 no stale output", q.size(), 0);
    send_block(0, -1, 1'b0);
    s_last = last_cyc;
    idle();
    wait_q(NB);
    check("s6 count", q.size(), NB);
    check("s6 latency", q[0].cyc, s_last + 3);
    check_block(0, 0, "s6");
    check("s6 err", err_cnt, 0);

    check("idle outputs zero", idle_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prach_unreshape_ch.md
PRACH_UNRESHAPE_CH -- requirements
Module: prach_unreshape_ch

Interface
REQ-001 Parameter SIZE, default 64: samples per channel per block.
REQ-002 Parameter NCH, default 4: channels per block, 1..256.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din_dp1  input  16  first word of input beat.
REQ-006 din_dp2  input  16  second word of input beat.
REQ-007 din_dv  input  1  input beat valid; no backpressure, at most one beat per cycle.
REQ-008 din_chn  input  8  channel tag of input beat.
REQ-009 sync_in  input  1  frame start; qualifies the beat on the same cycle.
REQ-010 dout_dq1  output  16  first word of output beat.
REQ-011 dout_dq2  output  16  second word of output beat.
REQ-012 dout_dv  output  1  output beat valid.
REQ-013 dout_chn  output  8  channel index of output beat.
REQ-014 sync_out  output  1  one-cycle pulse on first beat of each output block.
REQ-015 err  output  1  one-cycle pulse on channel mismatch or overflow.

Function
REQ-016 Input block order is channel-major: channel 0 samples 0..SIZE-1, then channel 1, ..., then channel NCH-1; each beat is a (dp1, dp2) pair.
REQ-017 Output block order is sample-major: sample 0 of channels 0..NCH-1, then sample 1, ..., through sample SIZE-1; dout_dq1/dout_dq2 carry the stored dp1/dp2 unchanged.
REQ-018 Storage is a ping-pong buffer of 2 banks x NCH*SIZE x 32 bits.
REQ-019 Write address is wr_ch*SIZE + wr_k; wr_k increments on each din_dv and wraps at SIZE, where wr_ch increments.
REQ-020 The beat completing a bank (wr_ch=NCH-1, wr_k=SIZE-1) marks the bank full, toggles the write bank, and clears the write counters.
REQ-021 Read FSM states: IDLE and READ.
REQ-022 IDLE->READ on the cycle after a bank becomes full.
REQ-023 READ issues one address per cycle, rd_ch inner (0..NCH-1) and rd_k outer (0..SIZE-1).
REQ-024 READ->IDLE after NCH*SIZE addresses.
REQ-025 Output latency: first dout_dv is asserted at the 2nd rising edge after the edge sampling the last input beat of the bank.
REQ-026 Output beats are contiguous: exactly NCH*SIZE consecutive dout_dv cycles per block.
REQ-027 dout_chn equals rd_ch of the beat.
REQ-028 sync_out is asserted with the beat rd_k=0, rd_ch=0.
REQ-029 sync_in with din_dv forces that beat to index 0 (wr_ch=0, wr_k=0) of the current write bank, discarding any partial bank.
REQ-030 sync_in without din_dv clears the write counters and discards any partial bank.
REQ-031 sync_in does not affect a bank being read.
REQ-032 A din_dv beat whose din_chn differs from wr_ch pulses err one cycle later; the beat is still written at the computed address.
REQ-033 If a bank becomes full while READ is active, err pulses, the new bank is dropped, and reading continues undisturbed.
REQ-034 Bank-full and READ-done in the same cycle are not overflow; the FSM enters READ again on the next cycle.
REQ-035 While dout_dv is low, dout_dq1, dout_dq2 and dout_chn hold 0.

Reset
REQ-036 rst_n low asynchronously clears all counters, bank pointers and full flags, forces the FSM to IDLE, and drives every output to 0.
REQ-037 Reset mid-block discards all buffered data; the first block after reset starts at index 0.
REQ-038 RAM contents are not reset.

Structure
REQ-039 SIZE, NCH defaults and the read-FSM state enum are defined in shared package prach_pkg.
REQ-040 Storage is one sub-module prach_dpram: simple dual-port, 1-cycle registered read, write-first irrelevant.
REQ-041 The output register stage resides in prach_unreshape_ch.

Verification
REQ-042 Scenario 1: NCH=4, SIZE=64; one block, din_dv continuous, dp1={chn,k}, dp2=~dp1, sync_in on the first beat -> 256 contiguous output beats, beat n has dq1={n%4, n/4}, sync_out on beat 0, first dout_dv 2 cycles after the last input beat.
REQ-043 Scenario 2: three back-to-back blocks at full rate -> 768 output beats in order, no err, every bank correct.
REQ-044 Scenario 3: din_dv at 50% random duty -> output identical to scenario 1, each block burst contiguous.
REQ-045 Scenario 4: sync_in re-asserted at input beat 100 of a block -> partial block discarded, next 256 beats form a block, exactly one output block.
REQ-046 Scenario 5: din_chn=3 on input beat 5 (expected 0) -> err pulses once, data still emitted at sample 5 of channel 0.
REQ-047 Scenario 6: rst_n low during the 10th output beat -> all outputs 0 immediately; a following block with sync_in reproduces scenario 1 output.
